sound_player: RTL and testbench
===============================

# sound_player

Consumer end of the logo sound interface: watches the `code_sound`/`mute` pair driven by the logo dynamics and turns each new sound code into a short square-wave tone sequence on a single speaker pin. Sits beside `logo` at the top level, fed directly from its `code_sound` and `mute` outputs, and drives the board buzzer.

## Interface

- `CLK_HZ`, default 12_000_000: system clock frequency. All tone and duration counts are derived from it at elaboration.
- `clk`  in  1  system clock.
- `clr`  in  1  synchronous, active-low reset.
- `code_sound`  in  2  sound code: 0 = ping, 1 = pong, 2 = go, 3 = stop.
- `mute`  in  1  1 = force speaker low; sequencing continues.
- `spk`  out  1  square-wave speaker output, registered.
- `busy`  out  1  1 while a sequence is playing, registered.

## Operation

- Derived constants, integer division:
  - `HALF_HI = CLK_HZ/2094` (about 1047 Hz).
  - `HALF_LO = CLK_HZ/1046` (about 523 Hz).
  - `MS_DIV = CLK_HZ/1000`.
- Sequence table:
  - ping: HI for 60 ms.
  - pong: LO for 60 ms.
  - go: LO for 100 ms, then HI for 100 ms.
  - stop: HI for 100 ms, then LO for 100 ms.
- Trigger: `last_code` register holds the previous sampled `code_sound`. A sequence starts on any edge where `primed`=1 and `code_sound != last_code`. `last_code` updates every cycle.
- `primed` behaviour: cleared by reset, set on the first cycle after reset. That first cycle only loads `last_code` and never triggers.
- States:
  - IDLE → PLAY on trigger.
  - PLAY → PLAY (`note_idx` advances) at the end of note 0 of a two-note sequence.
  - PLAY → IDLE at the end of the last note.
- Note start (trigger or advance):
  - `tone` set to 1.
  - Half-period counter loaded with `HALF-1`.
  - ms prescaler and ms counter cleared.
- Tone: the half-period counter decrements each cycle. At 0, `tone` toggles and the counter reloads `HALF-1`.
- Duration: the prescaler counts 0..`MS_DIV-1`, and the ms counter increments on wrap. The note ends on the edge where the ms counter reaches `DUR` (the note's duration in ms), so each note lasts exactly `DUR*MS_DIV` cycles.
- Output: `spk <= tone_next & ~mute` in PLAY, and 0 in IDLE.
- Preemption: a trigger during PLAY restarts immediately with the new code at note 0. The old sequence is abandoned.
- Widths: counters are sized with `$clog2` of their maximum count. No wrap beyond the terminal count.

## Timing

- Reset (`clr`=0 at an edge): state IDLE, `spk`=0, `busy`=0, `primed`=0, `last_code`=0, all counters 0. Reset mid-sequence aborts it the same edge.
- Trigger latency: code change visible at edge E → `busy`=1 and `spk`=1 (if unmuted) after edge E.
- First toggle: `spk` falls `HALF` cycles after the start edge, then toggles every `HALF` cycles.
- Note boundary: at the advancing edge `spk` is forced high (phase restart), even if it was high already.
- End: at the final edge `busy`=0 and `spk`=0 together.
- `mute` affects `spk` one edge after it is sampled. It has no effect on `busy` or on durations.
- A code change on the same edge as an end-of-sequence gives priority to the trigger: state stays PLAY with the new code and `busy` never drops.

## Structure

- Shared header `sound_defs`: code constants `SND_PING`/`SND_PONG`/`SND_GO`/`SND_STOP`, to be included by `dynamic` and `sound_player` alike; frequency and duration constants.
- Sub-module `tone_gen`: half-period counter plus `tone` flip-flop, with `load`, `half` inputs and a `tone` output.
- Sequence table: a combinational case on (code, `note_idx`) inside `sound_player`.

## Test plan

All scenarios use `CLK_HZ`=1_000_000, giving `HALF_HI`=477, `HALF_LO`=956, `MS_DIV`=1000.

- **Reset/prime:** hold `clr`=0 for 5 cycles with `code_sound`=2, release → no trigger; `busy`=0 and `spk`=0 for 1000 cycles.
- **Ping:** change code 2→0 → `busy` high for exactly 60000 cycles; `spk` high 477 / low 477 alternating, starting high the edge after the change.
- **Go:** change code 0→2 → 956-cycle half-periods for 100000 cycles, then 477-cycle half-periods for 100000 cycles; `busy` drops after exactly 200000 cycles.
- **Mute:** during stop, assert `mute` for 5000 cycles → `spk`=0 from the next edge; `busy` and total length (200000) unchanged; the tone resumes in its running phase.
- **Preempt:** start stop, change to pong after 30000 cycles → `spk` restarts high that edge with 956-cycle half-periods; `busy` drops 60000 cycles later.
- **Reset mid-play:** pull `clr` low during note 1 of go → `spk`=0 and `busy`=0 after that edge; no trigger on the first cycle after release.

Source files
------------

// File: rtl/sound_player_pkg.sv
// rtl/sound_player_pkg.sv - sound codes, tone/duration constants and player state type
package sound_player_pkg;

   localparam logic [1:0] SND_PING = 2'd0;
   localparam logic [1:0] SND_PONG = 2'd1;
   localparam logic [1:0] SND_GO   = 2'd2;
   localparam logic [1:0] SND_STOP = 2'd3;

   // Divisors are twice the tone frequency, so CLK_HZ/div gives one half-period.
   localparam int HI_DIV   = 2094;
   localparam int LO_DIV   = 1046;
   localparam int MS_PER_S = 1000;

   localparam int DUR_W = 7;
   localparam logic [DUR_W-1:0] DUR_SHORT = 7'd60;
   localparam logic [DUR_W-1:0] DUR_LONG  = 7'd100;

   typedef enum logic {ST_IDLE, ST_PLAY} state_t;

endpackage

// File: rtl/sound_player_tone_gen.sv
// rtl/sound_player_tone_gen.sv - half-period counter driving the square-wave tone flop
module tone_gen #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] half,
   output logic         tone_next
);

   logic         tone;
   logic [W-1:0] cnt;
   logic [W-1:0] cnt_next;

   // A load always restarts the phase high, even if the tone was already high.
   always_comb begin
      cnt_next  = cnt - W'(1);
      tone_next = tone;
      if (load) begin
         cnt_next  = half - W'(1);
         tone_next = 1'b1;
      end else if (cnt == '0) begin
         cnt_next  = half - W'(1);
         tone_next = ~tone;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         cnt  <= '0;
         tone <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         tone <= tone_next;
      end
   end

endmodule

// File: rtl/sound_player.sv
// rtl/sound_player.sv - turns each new sound code into a timed square-wave tone sequence
module sound_player
   import sound_player_pkg::*;
#(
   parameter int CLK_HZ = 12_000_000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [1:0] code_sound,
   input  logic       mute,
   output logic       spk,
   output logic       busy
);

   localparam int HALF_HI = CLK_HZ / HI_DIV;
   localparam int HALF_LO = CLK_HZ / LO_DIV;
   localparam int MS_DIV  = CLK_HZ / MS_PER_S;
   localparam int HW      = $clog2(HALF_LO + 1);
   localparam int PW      = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

   state_t           state;
   logic             primed;
   logic [1:0]       last_code;
   logic [1:0]       code_r;
   logic             note_idx;
   logic [PW-1:0]    pre;
   logic [DUR_W-1:0] ms;

   logic [DUR_W-1:0] cur_dur;
   logic             cur_last;
   logic             trigger;
   logic             pre_wrap;
   logic             note_end;
   logic             advance;
   logic [1:0]       sel_code;
   logic             sel_idx;
   logic [HW-1:0]    half;
   logic             tone_next;

   function automatic logic note_is_hi(input logic [1:0] code, input logic idx);
      case (code)
         SND_PING: note_is_hi = 1'b1;
         SND_PONG: note_is_hi = 1'b0;
         SND_GO:   note_is_hi = idx;
         default:  note_is_hi = ~idx;
      endcase
   endfunction

   always_comb begin
      cur_dur  = DUR_LONG;
      cur_last = note_idx;
      case ({code_r, note_idx})
         {SND_PING, 1'b0}, {SND_PING, 1'b1},
         {SND_PONG, 1'b0}, {SND_PONG, 1'b1}: begin
            cur_dur  = DUR_SHORT;
            cur_last = 1'b1;
         end
         default: ;
      endcase
   end

   assign trigger  = primed && (code_sound != last_code);
   assign pre_wrap = (pre == PW'(MS_DIV - 1));
   assign note_end = (state == ST_PLAY) && pre_wrap && (ms == cur_dur - DUR_W'(1));
   assign advance  = note_end && !cur_last;

   // The pitch loaded must be that of the note about to start, not the one ending.
   assign sel_code = trigger ? code_sound : code_r;
   assign sel_idx  = trigger ? 1'b0 : (advance ? 1'b1 : note_idx);
   assign half     = note_is_hi(sel_code, sel_idx) ? HW'(HALF_HI) : HW'(HALF_LO);

   tone_gen #(.W(HW)) u_tone (
      .clk       (clk),
      .clr       (clr),
      .load      (trigger || advance),
      .half      (half),
      .tone_next (tone_next)
   );

   always_ff @(posedge clk) begin
      if (!clr) begin
         state     <= ST_IDLE;
         spk       <= 1'b0;
         busy      <= 1'b0;
         primed    <= 1'b0;
         last_code <= 2'd0;
         code_r    <= 2'd0;
         note_idx  <= 1'b0;
         pre       <= '0;
         ms        <= '0;
      end else begin
         primed    <= 1'b1;
         last_code <= code_sound;
         if (trigger) begin
            state    <= ST_PLAY;
            busy     <= 1'b1;
            code_r   <= code_sound;
            note_idx <= 1'b0;
            pre      <= '0;
            ms       <= '0;
            spk      <= tone_next & ~mute;
         end else if (state == ST_PLAY) begin
            if (note_end && cur_last) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               spk   <= 1'b0;
            end else begin
               spk <= tone_next & ~mute;
               if (advance) begin
                  note_idx <= 1'b1;
                  pre      <= '0;
                  ms       <= '0;
               end else if (pre_wrap) begin
                  pre <= '0;
                  ms  <= ms + DUR_W'(1);
               end else begin
                  pre <= pre + PW'(1);
               end
            end
         end else begin
            spk <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sound_player.sv
// tb/tb_sound_player.sv - directed and randomized checks of sound_player against a timing model
module tb_sound_player;

   localparam int CLK_HZ  = 50_000;
   localparam int HALF_HI = CLK_HZ / 2094;  // 23
   localparam int HALF_LO = CLK_HZ / 1046;  // 47
   localparam int MS_DIV  = CLK_HZ / 1000;  // 50

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       mute = 1'b0;
   logic [1:0] code_sound = 2'd2;
   logic       spk;
   logic       busy;

   int total = 0;
   int bad   = 0;

   sound_player #(.CLK_HZ(CLK_HZ)) dut (
      .clk        (clk),
      .clr        (clr),
      .code_sound (code_sound),
      .mute       (mute),
      .spk        (spk),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic int half_of(input logic [1:0] c, input int idx);
      case (c)
         2'd0:    return HALF_HI;
         2'd1:    return HALF_LO;
         2'd2:    return (idx != 0) ? HALF_HI : HALF_LO;
         default: return (idx != 0) ? HALF_LO : HALF_HI;
      endcase
   endfunction

   function automatic int note_cycles(input logic [1:0] c);
      return (c < 2'd2) ? 60 * MS_DIV : 100 * MS_DIV;
   endfunction

   function automatic int seq_cycles(input logic [1:0] c);
      return (c < 2'd2) ? note_cycles(c) : 2 * note_cycles(c);
   endfunction

   // t = cycles elapsed since the edge that started the sequence.
   function automatic logic tone_at(input logic [1:0] c, input int t);
      int p;
      int h;
      p = t;
      h = half_of(c, 0);
      if (c >= 2'd2 && t >= note_cycles(c)) begin
         p = t - note_cycles(c);
         h = half_of(c, 1);
      end
      return ((p / h) % 2) == 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   bit         m_valid  = 0;
   bit         m_primed = 0;
   bit         m_play   = 0;
   bit         m_mute   = 0;
   logic [1:0] m_last   = 2'd0;
   logic [1:0] m_code   = 2'd0;
   int         m_t      = 0;

   always @(posedge clk) begin
      m_valid = 1;
      if (!clr) begin
         m_primed = 0;
         m_last   = 2'd0;
         m_play   = 0;
         m_t      = 0;
      end else begin
         if (m_primed && code_sound != m_last) begin
            m_play = 1;
            m_code = code_sound;
            m_t    = 0;
         end else if (m_play) begin
            m_t++;
            if (m_t >= seq_cycles(m_code)) m_play = 0;
         end
         m_primed = 1;
         m_last   = code_sound;
         m_mute   = mute;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("busy", busy, m_play);
         check("spk", spk, m_play && !m_mute && tone_at(m_code, m_t));
      end
   end

   // Counts busy samples from the trigger; applies code change, mute window and reset at sample indices.
   task automatic run_seq(input logic [1:0] c, input int chg_at, input logic [1:0] c2,
                          input int mute_on, input int mute_off, input int rst_at,
                          output int len, output int first_low);
      @(negedge clk);
      code_sound = c;
      len = 0;
      first_low = -1;
      for (int n = 0; n < 40000; n++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         len++;
         if (first_low < 0 && spk === 1'b0) first_low = n;
         if (n == chg_at) code_sound = c2;
         mute = (n >= mute_on && n < mute_off);
         clr  = (n != rst_at);
      end
      clr  = 1'b1;
      mute = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int len;
      int fl;
      int used;
      int hold;

      repeat (5) @(negedge clk);
      clr = 1'b1;
      repeat (200) @(negedge clk);
      check("prime_busy", busy, 0);
      check("prime_spk", spk, 0);

      run_seq(2'd0, -1, 2'd0, 0, 0, -1, len, fl);
      check("ping_len", len, 3000);
      check("ping_first_low", fl, 23);

      run_seq(2'd2, -1, 2'd0, 0, 0, -1, len, fl);
      check("go_len", len, 10000);
      check("go_first_low", fl, 47);

      // Stop preempted by pong: 1501 stop samples, then a full 3000-cycle pong.
      run_seq(2'd3, 1500, 2'd1, 0, 0, -1, len, fl);
      check("preempt_len", len, 4501);
      check("preempt_first_low", fl, 23);

      run_seq(2'd3, -1, 2'd0, 1000, 1250, -1, len, fl);
      check("mute_len", len, 10000);
      check("mute_first_low", fl, 23);

      // Pong arrives on the very edge ping ends: busy must stay high throughout.
      run_seq(2'd0, 2999, 2'd1, 0, 0, -1, len, fl);
      check("coincide_len", len, 6000);
      check("coincide_first_low", fl, 23);

      run_seq(2'd2, -1, 2'd0, 0, 0, 7000, len, fl);
      check("reset_len", len, 7001);
      check("reset_first_low", fl, 47);
      repeat (100) @(negedge clk);
      check("reset_no_trigger_busy", busy, 0);
      check("reset_no_trigger_spk", spk, 0);

      used = 0;
      while (used < 15000) begin
         hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : $urandom_range(500, 4000);
         @(negedge clk);
         code_sound = 2'($urandom_range(0, 3));
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) mute = ~mute;
            clr = ($urandom_range(0, 3999) != 0);
         end
         used += hold + 1;
      end
      clr  = 1'b1;
      mute = 1'b0;
      repeat (10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
